// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and port indices for the mem_arbiter slice
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD_ADDR = 2'd2,
        RD_DATA = 2'd3
    } state_t;

    localparam int PORT_FETCH = 0;
    localparam int PORT_LDST  = 1;

endpackage

// File: rtl/mem_arbiter_arb2.sv
// rtl/mem_arbiter_arb2.sv - two-requester grant logic; MEM_ARB_RR_EN selects round-robin
// over the default fixed priority (port 1 over port 0).
module arb2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

`ifdef MEM_ARB_RR_EN
    logic last_q;
    logic last_d;

    // last_q holds the index of the most recently accepted port; on a tie the other one wins.
    always_comb begin
        grant  = req;
        if (req == 2'b11) begin
            grant = last_q ? 2'b01 : 2'b10;
        end
        last_d = last_q;
        if (accept && (grant != 2'b00)) begin
            last_d = grant[PORT_LDST];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    logic unused_rr;
    assign unused_rr = clk ^ rst ^ accept;

    always_comb begin
        grant = 2'b00;
        if (req[PORT_LDST]) begin
            grant[PORT_LDST] = 1'b1;
        end else if (req[PORT_FETCH]) begin
            grant[PORT_FETCH] = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port arbiter/sequencer for a single-port cs/we/oe memory with shared data bus.
// Arbitration policy comes from arb2 (MEM_ARB_RR_EN enables round-robin).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_valid,
    output logic                  p0_ready,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_rvalid,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    input  logic                  p1_valid,
    output logic                  p1_ready,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_rvalid,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe,
    inout  wire  [DATA_WIDTH-1:0] mem_data
);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  port_q, port_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
    logic                  rvalid0_q, rvalid0_d;
    logic                  rvalid1_q, rvalid1_d;
    logic                  cs_q, cs_d;
    logic                  we_q, we_d;
    logic                  oe_q, oe_d;

    logic       idle;
    logic [1:0] grant;
    logic       accept;
    logic       sel_we;

    assign idle   = (state_q == IDLE) && !rst;
    assign accept = |grant;

    arb2 u_arb2 (
        .clk    (clk),
        .rst    (rst),
        .req    ({p1_valid, p0_valid} & {2{idle}}),
        .accept (accept),
        .grant  (grant)
    );

    assign p0_ready = grant[PORT_FETCH];
    assign p1_ready = grant[PORT_LDST];
    assign sel_we   = grant[PORT_LDST] ? p1_we : p0_we;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        port_d    = port_q;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        cs_d      = 1'b0;
        we_d      = 1'b0;
        oe_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    port_d  = grant[PORT_LDST];
                    addr_d  = grant[PORT_LDST] ? p1_addr  : p0_addr;
                    wdata_d = grant[PORT_LDST] ? p1_wdata : p0_wdata;
                    cs_d    = 1'b1;
                    if (sel_we) begin
                        state_d = WR;
                        we_d    = 1'b1;
                    end else begin
                        state_d = RD_ADDR;
                        oe_d    = 1'b1;
                    end
                end
            end
            WR: begin
                state_d = IDLE;
            end
            RD_ADDR: begin
                state_d = RD_DATA;
                cs_d    = 1'b1;
                oe_d    = 1'b1;
            end
            RD_DATA: begin
                // Memory drives the bus this cycle; capture into the requesting port only.
                state_d = IDLE;
                if (port_q == 1'(PORT_LDST)) begin
                    rdata1_d  = mem_data;
                    rvalid1_d = 1'b1;
                end else begin
                    rdata0_d  = mem_data;
                    rvalid0_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            port_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            cs_q      <= 1'b0;
            we_q      <= 1'b0;
            oe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            port_q    <= port_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            cs_q      <= cs_d;
            we_q      <= we_d;
            oe_q      <= oe_d;
        end
    end

    // Controls are gated by rst so a write caught mid-cycle never reaches the array.
    assign mem_cs      = cs_q && !rst;
    assign mem_we      = we_q && !rst;
    assign mem_oe      = oe_q && !rst;
    assign mem_address = ((state_q != IDLE) && !rst) ? addr_q : '0;
    assign mem_data    = mem_we ? wdata_q : 'z;

    assign p0_rvalid = rvalid0_q;
    assign p1_rvalid = rvalid1_q;
    assign p0_rdata  = rdata0_q;
    assign p1_rdata  = rdata1_q;

endmodule
